reset_sequencer: RTL

Power-up and run-time reset controller between the board reset pin, the PLL lock output and the system blocks (control unit, status LEDs).
- Holds all downstream logic in reset until the PLL lock has been stable for a programmable time.
- Then releases peripheral reset, then core reset after a stagger delay, and drives the idle indication.
- Re-sequences on PLL lock loss and supports a core-only soft reset.

---
 rtl/reset_sequencer_pkg.sv | 25 ++
 rtl/reset_sequencer_bit_synchronizer.sv | 31 +++
 rtl/reset_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared types and constants for the reset sequencer
//
// Purpose : FSM state encoding, lock-loss counter width and a small helper
//           used to size the shared sequencing counter.
// Ports   : none (package).
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_PERIPH_UP = 3'd3,
    S_RUN       = 3'd4,
    S_SOFT_HOLD = 3'd5
  } seq_state_t;

  localparam int LOCK_LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_bit_synchronizer.sv
// rtl/reset_sequencer_bit_synchronizer.sv - multi-flop single-bit synchronizer
//
// Purpose : Brings a single asynchronous bit into the clk domain through a
//           STAGES-deep flop chain, asynchronously cleared to RESET_VAL.
// Ports   : clk      - destination clock
//           N_RESET  - asynchronous active-low clear
//           d        - asynchronous input bit
//           q        - synchronized output (last stage)
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic N_RESET,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-up / run-time reset sequencer
//
// Purpose : Holds downstream logic in reset until PLL lock has been stable,
//           releases peripheral reset then core reset after a stagger delay,
//           re-sequences on lock loss and supports a core-only soft reset.
// Ports   : clk             - system clock (PLL output)
//           N_RESET         - board reset, asynchronous active-low
//           pll_lock        - PLL lock, asynchronous to clk
//           soft_reset_req  - single-cycle core-only reset request
//           periph_reset    - active-high peripheral reset
//           core_reset      - active-high control-unit reset
//           idle            - 1 whenever the state is not S_RUN
//           seq_state       - current FSM state encoding
//           lock_loss_count - saturating count of lock losses after release
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 16,
  parameter int SOFT_HOLD_CYCLES   = 8,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                       clk,
  input  logic                       N_RESET,
  input  logic                       pll_lock,
  input  logic                       soft_reset_req,
  output logic                       periph_reset,
  output logic                       core_reset,
  output logic                       idle,
  output logic [2:0]                 seq_state,
  output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_count
);

  // The counter only ever reaches (parameter - 1), so clog2 of the largest
  // parameter is enough and it can never wrap.
  localparam int MAX_CYCLES = max3(LOCK_STABLE_CYCLES, STAGGER_CYCLES, SOFT_HOLD_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_HOLD_CYCLES - 1);

  logic rst_sync;
  logic lock_s;

  seq_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       periph_q, periph_d;
  logic                       core_q, core_d;
  logic                       idle_q, idle_d;
  logic [LOCK_LOSS_CNT_W-1:0] llc_q, llc_d;

  // Reset-release chain: shifts in a constant 1 once N_RESET is deasserted.
  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_rst_sync (
    .clk     (clk),
    .N_RESET (N_RESET),
    .d       (1'b1),
    .q       (rst_sync)
  );

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk     (clk),
    .N_RESET (N_RESET),
    .d       (pll_lock),
    .q       (lock_s)
  );

  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      core_q   <= 1'b1;
      idle_q   <= 1'b1;
      llc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      idle_q   <= idle_d;
      llc_q    <= llc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    llc_d    = llc_q;

    case (state_q)
      S_RESET: begin
        cnt_d = '0;
        if (rst_sync) begin
          state_d = S_WAIT_LOCK;
        end
      end

      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = S_STABLE;
        end
      end

      // Dropping lock before release is just a restart, not a lock loss.
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d  = S_PERIPH_UP;
          periph_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PERIPH_UP: begin
        if (cnt_q == STAGGER_LAST) begin
          state_d = S_RUN;
          core_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = '0;
        if (soft_reset_req) begin
          state_d = S_SOFT_HOLD;
          core_d  = 1'b1;
        end
      end

      S_SOFT_HOLD: begin
        if (cnt_q == SOFT_LAST) begin
          state_d = S_RUN;
          core_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = S_RESET;
        cnt_d    = '0;
        periph_d = 1'b1;
        core_d   = 1'b1;
      end
    endcase

    // Lock loss after release overrides whatever the state logic decided,
    // which gives it priority over soft reset and counter expiry.
    if (!lock_s && (state_q == S_PERIPH_UP || state_q == S_RUN || state_q == S_SOFT_HOLD)) begin
      state_d  = S_WAIT_LOCK;
      cnt_d    = '0;
      periph_d = 1'b1;
      core_d   = 1'b1;
      if (llc_q != {LOCK_LOSS_CNT_W{1'b1}}) begin
        llc_d = llc_q + 1'b1;
      end
    end

    idle_d = (state_d != S_RUN);
  end

  assign periph_reset    = periph_q;
  assign core_reset      = core_q;
  assign idle            = idle_q;
  assign seq_state       = state_q;
  assign lock_loss_count = llc_q;

endmodule
